// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared multicycle RV32I datapath (single ALU, memory and immediate extender).
// Optional feature macro: RISCV_ILLEGAL_TRAP_EN adds a sticky illegal flag and a terminal HALT state.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluControl,
    output logic [2:0] immSrc,
    output logic       illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_LINK     = 4'd11,
        S_BRANCH   = 4'd12,
`ifdef RISCV_ILLEGAL_TRAP_EN
        S_LUI      = 4'd13,
        S_HALT     = 4'd14
`else
        S_LUI      = 4'd13
`endif
    } state_t;

    state_t state, state_next;
    logic   pc_update;
    logic   branch;
    logic   taken;

    // Shared by R-type and OP-IMM; only R-type may turn add into sub.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
        case (f3)
            3'b000:  alu_decode = sub_ok ? ALU_SUB : ALU_ADD;
            3'b010:  alu_decode = ALU_SLT;
            3'b100:  alu_decode = ALU_XOR;
            3'b110:  alu_decode = ALU_OR;
            3'b111:  alu_decode = ALU_AND;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= state_t'(RESET_STATE);
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_IMM:            state_next = S_EXEC_I;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_LUI:            state_next = S_LUI;
`ifdef RISCV_ILLEGAL_TRAP_EN
                    default:           state_next = S_HALT;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_EXEC_R,
            S_EXEC_I:   state_next = S_ALUWB;
            S_JAL,
            S_JALR:     state_next = S_LINK;
`ifdef RISCV_ILLEGAL_TRAP_EN
            S_HALT:     state_next = S_HALT;
`endif
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        pc_update  = 1'b0;
        branch     = 1'b0;
        taken      = 1'b0;
        adrSrc     = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        resultSrc  = RES_ALUOUT;
        aluSrcA    = SRCA_PC;
        aluSrcB    = SRCB_RS2;
        aluControl = ALU_ADD;
        case (state)
            S_FETCH: begin
                irWrite   = 1'b1;
                pc_update = 1'b1;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALURES;
            end
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
            end
            S_MEMREAD: adrSrc = 1'b1;
            S_MEMWB: begin
                resultSrc = RES_MEM;
                regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            S_EXEC_R: begin
                aluSrcA    = SRCA_RS1;
                aluSrcB    = SRCB_RS2;
                aluControl = alu_decode(funct3, funct7b5);
            end
            S_EXEC_I: begin
                aluSrcA    = SRCA_RS1;
                aluSrcB    = SRCB_IMM;
                aluControl = alu_decode(funct3, 1'b0);
            end
            S_ALUWB: regWrite = 1'b1;
            S_JAL:   pc_update = 1'b1;
            S_JALR: begin
                aluSrcA   = SRCA_RS1;
                aluSrcB   = SRCB_IMM;
                resultSrc = RES_ALURES;
                pc_update = 1'b1;
            end
            S_LINK: begin
                aluSrcA   = SRCA_OLDPC;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALURES;
                regWrite  = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_RS2;
                branch  = 1'b1;
                case (funct3)
                    3'b000: begin aluControl = ALU_SUB; taken = zero;  end
                    3'b001: begin aluControl = ALU_SUB; taken = ~zero; end
                    3'b100: begin aluControl = ALU_SLT; taken = ~zero; end
                    3'b101: begin aluControl = ALU_SLT; taken = zero;  end
                    default: taken = 1'b0;
                endcase
            end
            S_LUI: begin
                resultSrc = RES_IMM;
                regWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcWrite = pc_update | (branch & taken);

    always_comb begin
        case (opcode)
            OP_STORE:  immSrc = 3'b001;
            OP_BRANCH: immSrc = 3'b010;
            OP_JAL:    immSrc = 3'b011;
            OP_LUI:    immSrc = 3'b100;
            default:   immSrc = 3'b000;
        endcase
    end

`ifdef RISCV_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   illegal_q <= 1'b0;
        else if (state == S_DECODE && state_next == S_HALT) illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction step model compared every cycle,
// plus literal spot checks. Honours RISCV_ILLEGAL_TRAP_EN when defined.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [2:0] imm_src;
        logic       illegal;
    } outs_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB;
    logic [2:0] aluControl, immSrc;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
        .regWrite(regWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .aluControl(aluControl), .immSrc(immSrc), .illegal(illegal)
    );

    outs_t act;
    assign act = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc, aluSrcA, aluSrcB,
                  aluControl, immSrc, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

`ifdef RISCV_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Instruction classes derived from the opcode, independently of any FSM encoding.
    function automatic int instr_len(input logic [6:0] op);
        case (op)
            7'h03:                      return 5;
            7'h23, 7'h33, 7'h13,
            7'h6F, 7'h67:               return 4;
            7'h63, 7'h37:               return 3;
            default:                    return TRAP ? 12 : 2;
        endcase
    endfunction

    function automatic logic [2:0] fdec(input logic [2:0] f3, input logic sub_ok);
        case (f3)
            3'b000:  return sub_ok ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b100:  return 3'b100;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs on cycle k (0 = first cycle) of an instruction.
    function automatic outs_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                    input logic z, input int k);
        outs_t o;
        o = '0;
        case (op)
            7'h23:   o.imm_src = 3'b001;
            7'h63:   o.imm_src = 3'b010;
            7'h6F:   o.imm_src = 3'b011;
            7'h37:   o.imm_src = 3'b100;
            default: o.imm_src = 3'b000;
        endcase
        if (k == 0) begin
            o.ir_write = 1; o.pc_write = 1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
        end else if (k == 1) begin
            o.alu_src_a = 2'b01; o.alu_src_b = 2'b01;
        end else begin
            case (op)
                7'h03: if (k == 2) begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
                       else if (k == 3) o.adr_src = 1;
                       else begin o.result_src = 2'b01; o.reg_write = 1; end
                7'h23: if (k == 2) begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
                       else begin o.adr_src = 1; o.mem_write = 1; end
                7'h33: if (k == 2) begin o.alu_src_a = 2'b10; o.alu_control = fdec(f3, f7); end
                       else o.reg_write = 1;
                7'h13: if (k == 2) begin
                           o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_control = fdec(f3, 1'b0);
                       end else o.reg_write = 1;
                7'h6F, 7'h67: if (k == 2) begin
                           o.pc_write = 1;
                           if (op == 7'h67) begin
                               o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.result_src = 2'b10;
                           end
                       end else begin
                           o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.result_src = 2'b10;
                           o.reg_write = 1;
                       end
                7'h63: begin
                    o.alu_src_a = 2'b10;
                    case (f3)
                        3'b000: begin o.alu_control = 3'b001; o.pc_write = z;  end
                        3'b001: begin o.alu_control = 3'b001; o.pc_write = !z; end
                        3'b100: begin o.alu_control = 3'b101; o.pc_write = !z; end
                        3'b101: begin o.alu_control = 3'b101; o.pc_write = z;  end
                        default: ;
                    endcase
                end
                7'h37: begin o.result_src = 2'b11; o.reg_write = 1; end
                default: o.illegal = TRAP;
            endcase
        end
        return o;
    endfunction

    logic [6:0] m_op;
    logic [2:0] m_f3;
    logic       m_f7, m_z;
    int         m_k;
    bit         m_valid = 0;
    outs_t      trace [16];

    always @(negedge clk) begin
        if (m_valid) begin
            check($sformatf("step op=%02h f3=%0d k=%0d", m_op, m_f3, m_k), 32'(act),
                  32'(model(m_op, m_f3, m_f7, m_z, m_k)));
            trace[m_k] = act;
        end
    end

    // Starts in the FETCH cycle at posedge+1; returns at posedge+1 after n cycles.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int n);
        opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
        m_op = op; m_f3 = f3; m_f7 = f7; m_z = z;
        for (int k = 0; k < n; k++) begin
            m_k = k;
            m_valid = 1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        run_instr(op, f3, f7, z, instr_len(op));
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'h13; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        #12;
        check("reset irWrite", 32'(irWrite), 1);
        check("reset pcWrite", 32'(pcWrite), 1);
        check("reset aluSrcB", 32'(aluSrcB), 2);
        check("reset illegal", 32'(illegal), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(7'h03, 3'b010, 1'b0, 1'b0);
        check("lw wb regWrite", 32'(trace[4].reg_write), 1);
        check("lw wb resultSrc", 32'(trace[4].result_src), 1);
        check("lw early regWrite", 32'({trace[0].reg_write, trace[1].reg_write,
                                         trace[2].reg_write, trace[3].reg_write}), 0);
        check("lw immSrc", 32'(trace[2].imm_src), 0);

        run(7'h23, 3'b010, 1'b0, 1'b0);
        run(7'h33, 3'b000, 1'b1, 1'b0);
        check("R sub aluControl", 32'(trace[2].alu_control), 1);
        run(7'h13, 3'b000, 1'b1, 1'b0);
        check("OP-IMM add aluControl", 32'(trace[2].alu_control), 0);
        run(7'h33, 3'b000, 1'b0, 1'b0);
        run(7'h33, 3'b100, 1'b0, 1'b0);
        run(7'h33, 3'b110, 1'b0, 1'b0);
        run(7'h33, 3'b111, 1'b1, 1'b0);
        run(7'h13, 3'b010, 1'b0, 1'b0);
        run(7'h13, 3'b001, 1'b0, 1'b0);

        run(7'h63, 3'b000, 1'b0, 1'b1);
        check("beq z=1 pcWrite", 32'(trace[2].pc_write), 1);
        check("beq aluControl", 32'(trace[2].alu_control), 1);
        check("beq immSrc", 32'(trace[2].imm_src), 2);
        run(7'h63, 3'b000, 1'b0, 1'b0);
        check("beq z=0 pcWrite", 32'(trace[2].pc_write), 0);
        run(7'h63, 3'b101, 1'b0, 1'b1);
        check("bge z=1 pcWrite", 32'(trace[2].pc_write), 1);
        run(7'h63, 3'b101, 1'b0, 1'b0);
        run(7'h63, 3'b001, 1'b0, 1'b0);
        run(7'h63, 3'b100, 1'b0, 1'b1);
        run(7'h63, 3'b010, 1'b0, 1'b1);

        run(7'h6F, 3'b000, 1'b0, 1'b0);
        check("jal immSrc", 32'(trace[0].imm_src), 3);
        check("jal pcWrite", 32'(trace[2].pc_write), 1);
        check("link regWrite", 32'(trace[3].reg_write), 1);
        check("link aluSrcA", 32'(trace[3].alu_src_a), 1);
        check("link aluSrcB", 32'(trace[3].alu_src_b), 2);
        check("link resultSrc", 32'(trace[3].result_src), 2);
        run(7'h67, 3'b000, 1'b0, 1'b0);
        run(7'h37, 3'b000, 1'b0, 1'b0);

        // Abort a load in MEMREAD with a one-cycle reset pulse.
        run_instr(7'h03, 3'b010, 1'b0, 1'b0, 3);
        m_k = 3;
        @(negedge clk); #1;
        check("pre-abort adrSrc", 32'(adrSrc), 1);
        m_valid = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort irWrite", 32'(irWrite), 1);
        check("abort memWrite", 32'(memWrite), 0);
        check("abort regWrite", 32'(regWrite), 0);
        run(7'h03, 3'b010, 1'b0, 1'b0);

        run(7'h7F, 3'b000, 1'b0, 1'b0);
        if (TRAP) begin
            for (int k = 2; k < 12; k++) begin
                check($sformatf("halt pcWrite k=%0d", k), 32'(trace[k].pc_write), 0);
                check($sformatf("halt illegal k=%0d", k), 32'(trace[k].illegal), 1);
            end
            m_valid = 0;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            check("post-halt reset illegal", 32'(illegal), 0);
        end else begin
            check("nop illegal", 32'(trace[1].illegal), 0);
        end
        run(7'h37, 3'b000, 1'b0, 1'b0);
        check("after unknown irWrite", 32'(trace[0].ir_write), 1);

        m_valid = 0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
